// File: rtl/bf_sbox_f_unit.sv
// rtl/bf_sbox_f_unit.sv - Loadable Blowfish S-boxes with a two-stage F = ((S0+S1)^S2)+S3 pipeline
// Optional BF_SBOX_INIT_EN: after reset an INIT pass zeroes every entry while busy is high.
module bf_sbox_f_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [1:0]            wr_box,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*ADDR_W-1:0]   in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_f,
  output logic                  busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [DATA_W-1:0] r0, r1, r2, r3;
  logic              v1;
  logic              s2_free;
  logic              accept;
  logic              move;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] idx_a, idx_b, idx_c, idx_d;

`ifdef BF_SBOX_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    init_we   = 1'b0;
    case (state)
      S_INIT: begin
        busy    = 1'b1;
        init_we = 1'b1;
        if (init_cnt == {ADDR_W{1'b1}}) state_nxt = S_RUN;
      end
      default: ;
    endcase
  end

  assign init_addr = init_cnt;
`else
  assign busy      = 1'b0;
  assign init_we   = 1'b0;
  assign init_addr = '0;
`endif

  assign idx_a = in_x[4*ADDR_W-1 -: ADDR_W];
  assign idx_b = in_x[3*ADDR_W-1 -: ADDR_W];
  assign idx_c = in_x[2*ADDR_W-1 -: ADDR_W];
  assign idx_d = in_x[ADDR_W-1:0];

  // Writes block lookups outright, so a read never collides with a write.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = rst_n && !busy && !wr_en && (!v1 || s2_free);
  assign accept   = in_valid && in_ready;
  assign move     = v1 && s2_free;

  always_ff @(posedge clk) begin
    if (init_we) begin
      for (int k = 0; k < 4; k++) mem[k][init_addr] <= '0;
    end else if (wr_en && !busy) begin
      mem[wr_box][wr_addr] <= wr_data;
    end
  end

  // Read registers carry no reset: v1 qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      r0 <= mem[0][idx_a];
      r1 <= mem[1][idx_b];
      r2 <= mem[2][idx_c];
      r3 <= mem[3][idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_f     <= '0;
    end else begin
      if (accept)    v1 <= 1'b1;
      else if (move) v1 <= 1'b0;

      if (move) begin
        out_valid <= 1'b1;
        out_f     <= ((r0 + r1) ^ r2) + r3;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bf_sbox_f_unit.sv
// tb/tb_bf_sbox_f_unit.sv - Directed-vector bench for bf_sbox_f_unit
// Honours BF_SBOX_INIT_EN when the design is built with it.
module tb_bf_sbox_f_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_box;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bf_sbox_f_unit #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_box(wr_box), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic write_entry(input logic [1:0] box, input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_box = box; wr_addr = addr; wr_data = data;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] x, input logic [31:0] exp, input string name);
    int waited;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; out_ready = 1'b1;
    waited = 0;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1 waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid=%b required 0 one cycle after accept", name, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_f !== exp) begin
      errors++;
      $display("FAIL %s: out_valid=%b out_f=%h required 1 / %h", name, out_valid, out_f, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_box = '0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_f !== 32'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b out_f=%h in_ready=%b required 0/0/0", out_valid, out_f, in_ready);
    end
`ifdef BF_SBOX_INIT_EN
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b1;
`else
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required 0", busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
`endif
  endtask

`ifdef BF_SBOX_INIT_EN
  task automatic test_init();
    int high_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      #1;
      if (busy === 1'b1) high_cnt++;
      if (c == 10) begin
        wr_en = 1'b1; wr_box = 2'd0; wr_addr = 8'h01; wr_data = 32'hDEAD_BEEF;
        #1 checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL init_ready: in_ready=%b required 0", in_ready);
        end
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    checks++;
    if (high_cnt != 256) begin
      errors++;
      $display("FAIL init_busy_len: busy high for %0d samples required 256", high_cnt);
    end
    #1 checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init_busy_end: busy=%b required 0", busy);
    end
    do_lookup(32'h01020304, 32'h0, "init_zero");
    do_lookup(32'hFF80_7F00, 32'h0, "init_zero_b");
  endtask
`endif

  task automatic test_basic_f();
    write_entry(2'd0, 8'h01, 32'h0000_0010);
    write_entry(2'd1, 8'h02, 32'h0000_0020);
    write_entry(2'd2, 8'h03, 32'h0000_00FF);
    write_entry(2'd3, 8'h04, 32'h0000_0001);
    do_lookup(32'h01020304, 32'h0000_00D0, "basic_f");
  endtask

  task automatic test_modular_wrap();
    write_entry(2'd0, 8'h00, 32'hFFFF_FFFF);
    write_entry(2'd1, 8'h00, 32'h0000_0002);
    write_entry(2'd2, 8'h00, 32'h0000_0000);
    write_entry(2'd3, 8'h00, 32'hFFFF_FFFF);
    do_lookup(32'h0, 32'h0, "modular_wrap");
  endtask

  task automatic test_last_index();
    write_entry(2'd0, 8'hFF, 32'h0000_0005);
    write_entry(2'd1, 8'hFF, 32'h0000_0006);
    write_entry(2'd2, 8'hFF, 32'h0000_0003);
    write_entry(2'd3, 8'hFF, 32'h0000_0001);
    do_lookup(32'hFFFF_FFFF, 32'h0000_0009, "last_index");
  endtask

  task automatic test_write_priority();
    @(negedge clk);
    wr_en = 1'b1; wr_box = 2'd1; wr_addr = 8'h02; wr_data = 32'h0000_0120;
    in_valid = 1'b1; in_x = 32'h01020304; out_ready = 1'b1;
    #1 checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_blocks_lookup: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1 checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lookup_after_write: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_box = 2'd1; wr_addr = 8'h02; wr_data = 32'h0000_0020;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_f !== 32'h0000_01D0) begin
      errors++;
      $display("FAIL write_after_accept: out_valid=%b out_f=%h required 1 / 000001d0", out_valid, out_f);
    end
    do_lookup(32'h01020304, 32'h0000_00D0, "restored_entry");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8];
    bit   [3:0]  pat;
    int sent, recv, cyc;
    bit acc, ret;
    pat = 4'b1001;
    write_entry(2'd1, 8'h20, 32'h0);
    write_entry(2'd2, 8'h21, 32'h0);
    write_entry(2'd3, 8'h22, 32'h0);
    for (int i = 0; i < 8; i++) begin
      exp[i] = 32'h1000_0000 + 32'h111 * i;
      write_entry(2'd0, 8'h30 + 8'(i), exp[i]);
    end
    sent = 0; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_x      = {8'h30 + 8'(sent), 8'h20, 8'h21, 8'h22};
      #1;
      checks++;
      if (in_ready !== !((sent - recv) == 2 && !out_ready)) begin
        errors++;
        $display("FAIL stream_ready: cycle %0d in_ready=%b in_flight=%0d out_ready=%b", cyc, in_ready, sent - recv, out_ready);
      end
      if (out_valid) begin
        checks++;
        if (recv >= sent || out_f !== exp[recv % 8]) begin
          errors++;
          $display("FAIL stream_data: result %0d out_f=%h required %h", recv, out_f, exp[recv % 8]);
        end
      end
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      @(posedge clk);
      if (acc) sent++;
      if (ret) recv++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 8) begin
      errors++;
      $display("FAIL stream_count: received %0d results required 8", recv);
    end
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_x = 32'h01020304;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_before_reset: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1 checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_f !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b out_f=%h required 0/0/0", out_valid, in_ready, out_f);
    end
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef BF_SBOX_INIT_EN
    for (int c = 0; c < 300 && busy; c++) @(negedge clk);
    do_lookup(32'h01020304, 32'h0, "after_reset_cleared");
`else
    do_lookup(32'h01020304, 32'h0000_00D0, "after_reset_retained");
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef BF_SBOX_INIT_EN
    test_init();
`endif
    test_basic_f();
    test_modular_wrap();
    test_last_index();
    test_write_priority();
    test_back_to_back();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
